tt_um_td4_cpu: RTL and testbench
================================

// Module: tt_um_td4_cpu
// PURPOSE
//   TD4 4-bit CPU (classic 12-instruction teaching CPU) as a TinyTapeout user project top.
//   Executes one 8-bit instruction per clock from a 16x8 on-chip program memory.
//   Program memory is loaded over the IO pins in load mode; run mode drives OUT/PC to pins.
// PARAMETERS
//   none (widths fixed: 4-bit data, 4-bit PC, 16 x 8-bit program memory)
// PORTS
//   clk      in   1  system clock, all state updates on rising edge
//   rst_n    in   1  reset, asynchronous, active-low
//   ena      in   1  design enable; 0 = freeze all state (no PC advance, no writes)
//   ui_in    in   8  [3:0] IN port (run) / load address (load); [6] write strobe; [7] mode 1=load 0=run; [5:4] unused
//   uo_out   out  8  run: {PC[3:0], OUT[3:0]}; load: mem[ui_in[3:0]]
//   uio_in   in   8  program data byte for load-mode writes
//   uio_out  out  8  tied 8'h00
//   uio_oe   out  8  tied 8'h00 (all uio are inputs)
// BEHAVIOUR
//   State: A, B, OUT, PC (4b each), C carry flag (1b), mem[0:15] (8b each).
//   Reset (rst_n=0, async): A=B=OUT=PC=0, C=0, all mem words = 8'h00 (= ADD A,0 = NOP).
//   Load mode (ui_in[7]=1): CPU halted (A,B,OUT,PC,C hold);
//     posedge with ena=1 & ui_in[6]=1 -> mem[ui_in[3:0]] <= uio_in.
//     uo_out = mem[ui_in[3:0]] (combinational readback).
//   Run mode (ui_in[7]=0, ena=1): each posedge executes instr=mem[PC], op=instr[7:4], im=instr[3:0]:
//     0000 ADD A,im : {C,A} <= A+im          0101 ADD B,im : {C,B} <= B+im
//     0011 MOV A,im : A <= im                0111 MOV B,im : B <= im
//     0001 MOV A,B  : A <= B                 0100 MOV B,A  : B <= A
//     0010 IN A     : A <= ui_in[3:0]        0110 IN B     : B <= ui_in[3:0]
//     1001 OUT B    : OUT <= B               1011 OUT im   : OUT <= im
//     1111 JMP im   : PC <= im               1110 JNC im   : PC <= (C==0) ? im : PC+1
//     any other op  : NOP (no register write)
//   Non-jump instructions: PC <= PC+1, wrapping 15 -> 0.
//   Carry: ADD ops load C with 5th bit of 4-bit sum (sum wraps mod 16);
//     every non-ADD instruction (incl. JNC, JMP, undefined) clears C <= 0.
//   JNC samples C as it was before the JNC edge (set by the immediately preceding instruction).
//   Latency: results visible on uo_out the edge after the instruction executes; 1 instr/cycle, no stalls.
//   Mode switch run->load mid-program: state frozen; load->run resumes at held PC.
//   ena=0: no state change in either mode; outputs still reflect current state.
// TESTING
//   1 reset: rst_n=0 -> uo_out=8'h00, uio_oe=00; load readback of any addr = 8'h00.
//   2 load/readback: write 0xB5 to addr 0 (ui_in=8'hC0,uio_in=B5,1 clk); ui_in=8'h80 -> uo_out=8'hB5;
//     run 1 clk -> uo_out=8'h15 (PC=1, OUT=5).
//   3 arithmetic: prog 33,04,40,90 -> after 4 run clks uo_out=8'h47 (OUT=7, PC=4).
//   4 carry/JNC: prog 3F,01,E0 -> A=0,C=1, JNC not taken, PC=3; prog 3E,01,E7 -> JNC taken, PC=7.
//   5 IN: ui_in[3:0]=4'hA, prog 20,40,90 -> OUT=4'hA after 3 clks.
//   6 JMP/wrap: prog F5 at 0 -> PC=5; all-NOP mem runs 16 clks -> PC wraps to 0; ena=0 holds PC.

Source files
------------

// File: rtl/tt_um_td4_cpu.sv
// ---------------------------------------------------------------------------
// tt_um_td4_cpu
//   TD4 4-bit teaching CPU wrapped as a TinyTapeout user project.
//   One 8-bit instruction from a 16 x 8 program memory is executed per clock.
//   In load mode the CPU is halted and the program memory is written and read
//   back over the IO pins. In run mode the pins show {PC, OUT}.
//
// Ports
//   clk      : system clock, rising edge
//   rst_n    : asynchronous active-low reset (clears registers and memory)
//   ena      : 0 freezes every piece of state; outputs keep reflecting it
//   ui_in    : [3:0] IN port (run) / memory address (load)
//              [6] write strobe (load), [7] 1 = load mode, 0 = run mode
//   uo_out   : run = {PC, OUT}; load = mem[ui_in[3:0]]
//   uio_in   : program byte written in load mode
//   uio_out  : constant 0
//   uio_oe   : constant 0, the uio pins are inputs only
// ---------------------------------------------------------------------------
module tt_um_td4_cpu (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  localparam logic [3:0] OP_ADD_A = 4'b0000;
  localparam logic [3:0] OP_MOV_AB = 4'b0001;
  localparam logic [3:0] OP_IN_A  = 4'b0010;
  localparam logic [3:0] OP_MOV_A = 4'b0011;
  localparam logic [3:0] OP_MOV_BA = 4'b0100;
  localparam logic [3:0] OP_ADD_B = 4'b0101;
  localparam logic [3:0] OP_IN_B  = 4'b0110;
  localparam logic [3:0] OP_MOV_B = 4'b0111;
  localparam logic [3:0] OP_OUT_B = 4'b1001;
  localparam logic [3:0] OP_OUT_I = 4'b1011;
  localparam logic [3:0] OP_JNC   = 4'b1110;
  localparam logic [3:0] OP_JMP   = 4'b1111;

  logic [3:0] a_q, a_d;
  logic [3:0] b_q, b_d;
  logic [3:0] out_q, out_d;
  logic [3:0] pc_q, pc_d;
  logic       c_q, c_d;
  logic [7:0] mem_q [16];
  logic [7:0] mem_d [16];

  logic       load_mode;
  logic [3:0] addr;
  logic [3:0] in_port;
  logic [7:0] instr;
  logic [3:0] op;
  logic [3:0] im;
  logic [4:0] sum_a;
  logic [4:0] sum_b;
  logic [3:0] pc_inc;

  // ui_in[5:4] have no function in this design.
  logic unused_ui;
  assign unused_ui = ^ui_in[5:4];

  assign load_mode = ui_in[7];
  assign addr      = ui_in[3:0];
  assign in_port   = ui_in[3:0];

  assign instr  = mem_q[pc_q];
  assign op     = instr[7:4];
  assign im     = instr[3:0];
  assign sum_a  = {1'b0, a_q} + {1'b0, im};
  assign sum_b  = {1'b0, b_q} + {1'b0, im};
  assign pc_inc = pc_q + 4'd1;  // wraps 15 -> 0

  always_comb begin
    a_d   = a_q;
    b_d   = b_q;
    out_d = out_q;
    pc_d  = pc_q;
    c_d   = c_q;
    mem_d = mem_q;
    if (ena) begin
      if (load_mode) begin
        // CPU halted; only the addressed memory word may change.
        if (ui_in[6]) mem_d[addr] = uio_in;
      end else begin
        pc_d = pc_inc;
        // Only the ADDs produce a carry; every other instruction clears it.
        c_d  = 1'b0;
        case (op)
          OP_ADD_A:  {c_d, a_d} = sum_a;
          OP_ADD_B:  {c_d, b_d} = sum_b;
          OP_MOV_A:  a_d = im;
          OP_MOV_B:  b_d = im;
          OP_MOV_AB: a_d = b_q;
          OP_MOV_BA: b_d = a_q;
          OP_IN_A:   a_d = in_port;
          OP_IN_B:   b_d = in_port;
          OP_OUT_B:  out_d = b_q;
          OP_OUT_I:  out_d = im;
          OP_JMP:    pc_d = im;
          // c_q is the carry left by the previous instruction.
          OP_JNC:    pc_d = c_q ? pc_inc : im;
          default:   ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q   <= 4'h0;
      b_q   <= 4'h0;
      out_q <= 4'h0;
      pc_q  <= 4'h0;
      c_q   <= 1'b0;
      mem_q <= '{default: 8'h00};
    end else begin
      a_q   <= a_d;
      b_q   <= b_d;
      out_q <= out_d;
      pc_q  <= pc_d;
      c_q   <= c_d;
      mem_q <= mem_d;
    end
  end

  assign uo_out  = load_mode ? mem_q[addr] : {pc_q, out_q};
  assign uio_out = 8'h00;
  assign uio_oe  = 8'h00;

endmodule

// File: tb/tb_tt_um_td4_cpu.sv
// ---------------------------------------------------------------------------
// tb_tt_um_td4_cpu
//   Self-checking bench for tt_um_td4_cpu. A behavioural model of the TD4
//   instruction set runs alongside the DUT; every falling edge the DUT pins
//   are compared with the model. Directed programs pin the model with
//   hand-computed literals, then randomized programs and pin activity follow.
// ---------------------------------------------------------------------------
module tb_tt_um_td4_cpu;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       ena = 1'b1;
  logic [7:0] ui_in = 8'h80;
  logic [7:0] uio_in = 8'h00;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  always #5 clk = ~clk;

  tt_um_td4_cpu dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .ui_in   (ui_in),
    .uo_out  (uo_out),
    .uio_in  (uio_in),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  int errors = 0;
  int checks = 0;
  bit checking_on = 1'b0;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [7:0] m_mem [16];
  int m_a, m_b, m_out, m_pc, m_c;

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_mem[i] = 8'h00;
    m_a = 0; m_b = 0; m_out = 0; m_pc = 0; m_c = 0;
  endtask

  // One instruction, straight from the ISA table using integer arithmetic.
  task automatic model_exec(input int in_val);
    int opc, imm, nxt, carry, s;
    opc   = m_mem[m_pc] / 16;
    imm   = m_mem[m_pc] % 16;
    nxt   = (m_pc + 1) % 16;
    carry = 0;
    case (opc)
      0:  begin s = m_a + imm; carry = (s >= 16); m_a = s % 16; end
      5:  begin s = m_b + imm; carry = (s >= 16); m_b = s % 16; end
      3:  m_a = imm;
      7:  m_b = imm;
      1:  m_a = m_b;
      4:  m_b = m_a;
      2:  m_a = in_val;
      6:  m_b = in_val;
      9:  m_out = m_b;
      11: m_out = imm;
      15: nxt = imm;
      14: if (m_c == 0) nxt = imm;
      default: ;
    endcase
    m_c  = carry;
    m_pc = nxt;
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) model_reset();
    else if (ena) begin
      if (ui_in[7]) begin
        if (ui_in[6]) m_mem[ui_in[3:0]] = uio_in;
      end else begin
        model_exec(int'(ui_in[3:0]));
      end
    end
  end

  function automatic logic [7:0] model_out();
    if (ui_in[7]) return m_mem[ui_in[3:0]];
    return 8'((m_pc * 16) + m_out);
  endfunction

  // ---------------- scoreboard ----------------
  logic [7:0] exp_q[$];

  always @(negedge clk) begin
    if (checking_on && rst_n) begin
      logic [7:0] e;
      exp_q.push_back(model_out());
      e = exp_q.pop_front();
      check("uo_out", uo_out, e);
      check("uio_out", uio_out, 8'h00);
      check("uio_oe", uio_oe, 8'h00);
    end
  end

  // ---------------- driver tasks ----------------
  // Inputs change 2 time units after the rising edge; comparisons happen on
  // the falling edge, well clear of both.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic do_reset();
    ena   = 1'b1;
    ui_in = 8'h00;
    rst_n = 1'b0;
    #1;
    check("reset_uo", uo_out, 8'h00);
    check("reset_oe", uio_oe, 8'h00);
    tick(2);
    ui_in = 8'h80;  // released in load mode so nothing executes
    rst_n = 1'b1;
    tick(1);
  endtask

  task automatic load_byte(input logic [3:0] a, input logic [7:0] d);
    ui_in  = {4'hC, a};
    uio_in = d;
    tick(1);
    ui_in  = {4'h8, a};
  endtask

  task automatic load_prog(input logic [7:0] p[$]);
    foreach (p[i]) load_byte(4'(i), p[i]);
  endtask

  task automatic run(input logic [3:0] in_val, input int n);
    ui_in = {4'h0, in_val};
    tick(n);
  endtask

  // ---------------- directed + random stimulus ----------------
  initial begin
    do_reset();
    checking_on = 1'b1;

    // Reset leaves every memory word at 00.
    for (int a = 0; a < 16; a += 5) begin
      ui_in = 8'(8'h80 + a);
      #1;
      check("reset_mem", uo_out, 8'h00);
    end

    // Load/readback, then one OUT im.
    load_byte(4'h0, 8'hB5);
    ui_in = 8'h80;
    #1;
    check("readback", uo_out, 8'hB5);
    run(4'h0, 1);
    check("out_im", uo_out, 8'h15);

    // Arithmetic: A=3, A+=4, B=A, OUT B.
    do_reset();
    load_prog('{8'h33, 8'h04, 8'h40, 8'h90});
    run(4'h0, 4);
    check("arith", uo_out, 8'h47);

    // Carry set -> JNC falls through.
    do_reset();
    load_prog('{8'h3F, 8'h01, 8'hE0});
    run(4'h0, 3);
    check("jnc_not_taken", uo_out, 8'h30);

    // No carry -> JNC taken.
    do_reset();
    load_prog('{8'h3E, 8'h01, 8'hE7});
    run(4'h0, 3);
    check("jnc_taken", uo_out, 8'h70);

    // IN A path.
    do_reset();
    load_prog('{8'h20, 8'h40, 8'h90});
    run(4'hA, 3);
    check("in_a", uo_out, 8'h3A);

    // JMP.
    do_reset();
    load_byte(4'h0, 8'hF5);
    run(4'h0, 1);
    check("jmp", uo_out, 8'h50);

    // All-NOP memory wraps PC; ena=0 freezes it in both modes.
    do_reset();
    run(4'h0, 16);
    check("pc_wrap", uo_out, 8'h00);
    run(4'h0, 5);
    check("pc_5", uo_out, 8'h50);
    ena = 1'b0;
    run(4'h0, 3);
    check("ena_hold", uo_out, 8'h50);
    load_byte(4'h2, 8'h77);
    check("ena_no_write", uo_out, 8'h00);
    ena = 1'b1;

    // Run -> load mid-program holds PC; load -> run resumes there.
    run(4'h0, 2);
    check("pre_switch", uo_out, 8'h70);
    ui_in = 8'h80;
    tick(4);
    run(4'h0, 1);
    check("resume", uo_out, 8'h80);

    // Randomized programs and pin activity.
    for (int round = 0; round < 4; round++) begin
      do_reset();
      for (int a = 0; a < 16; a++) load_byte(4'(a), 8'($urandom_range(0, 255)));
      for (int cyc = 0; cyc < 400; cyc++) begin
        int r;
        r      = $urandom_range(0, 99);
        ena    = ($urandom_range(0, 99) < 90);
        uio_in = 8'($urandom_range(0, 255));
        if (r < 8)
          ui_in = {1'b1, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15))};
        else
          ui_in = {1'b0, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15))};
        if (r == 99) do_reset();
        else tick(1);
      end
    end

    checking_on = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
